// File: rtl/cpu_control_unit.sv
// cpu_control_unit: decodes the fetch word and sequences a small datapath
// (R1-R6, A, G, shared bus). It stalls fetch during multi-cycle ops by
// re-branching to a shadow copy of the fetch PC.
// Ports: clk, rst (async, active-high), instruction {op,rx,ry},
//   data_in (LOAD operand), branch/branchaddress (to fetch),
//   bus (datapath bus), done (last cycle of each instruction).
// Config: define CU_SUB_EN to make opcode 0100 a 4-cycle SUB.
module cpu_control_unit #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int DATA_W   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction,
  input  logic [DATA_W-1:0]                   data_in,
  output logic                                branch,
  output logic [3:0]                          branchaddress,
  output logic [DATA_W-1:0]                   bus,
  output logic                                done
);

  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

  localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(8);

  localparam logic [ARG_SIZE-1:0] IDX_PC = {ARG_SIZE{1'b1}};

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   g_q, g_d;
  logic [DATA_W-1:0]   r_q [1:6];
  logic [DATA_W-1:0]   r_d [1:6];
  logic [3:0]          pc_q, pc_d;

  logic [OP_SIZE-1:0]  in_op, ir_op;
  logic [ARG_SIZE-1:0] in_rx, in_ry, ir_rx, ir_ry;

  logic                branch_c;
  logic [3:0]          baddr_c;
  logic [DATA_W-1:0]   bus_c;
  logic                done_c;
  logic                wr_en;
  logic [ARG_SIZE-1:0] wr_idx;

  assign in_op = instruction[IW-1 -: OP_SIZE];
  assign in_rx = instruction[2*ARG_SIZE-1 -: ARG_SIZE];
  assign in_ry = instruction[ARG_SIZE-1:0];
  assign ir_op = ir_q[IW-1 -: OP_SIZE];
  assign ir_rx = ir_q[2*ARG_SIZE-1 -: ARG_SIZE];
  assign ir_ry = ir_q[ARG_SIZE-1:0];

  // Index 0 reads zero, index 7 reads the shadow PC.
  function automatic logic [DATA_W-1:0] rd(
    input logic [ARG_SIZE-1:0] idx
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == IDX_PC) v = DATA_W'(pc_q);
    for (int i = 1; i <= 6; i++)
      if (idx == ARG_SIZE'(i)) v = r_q[i];
    return v;
  endfunction

  function automatic logic is_multi(
    input logic [OP_SIZE-1:0] op
  );
`ifdef CU_SUB_EN
    return (op == OP_ADD) || (op == OP_XOR) ||
           (op == OP_SUB);
`else
    return (op == OP_ADD) || (op == OP_XOR);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] alu(
    input logic [OP_SIZE-1:0] op,
    input logic [DATA_W-1:0]  x,
    input logic [DATA_W-1:0]  y
  );
    logic [DATA_W-1:0] v;
    v = x + y;
    if (op == OP_XOR) v = x ^ y;
`ifdef CU_SUB_EN
    if (op == OP_SUB) v = x - y;
`endif
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    r_d      = r_q;
    branch_c = 1'b0;
    baddr_c  = '0;
    bus_c    = '0;
    done_c   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = ir_rx;

    unique case (state_q)
      T0: begin
        ir_d = instruction;
        if (is_multi(in_op)) begin
          state_d  = T1;
          branch_c = 1'b1;
          baddr_c  = pc_q;
        end else begin
          done_c = 1'b1;
          case (in_op)
            OP_LOAD: begin
              bus_c  = data_in;
              wr_en  = 1'b1;
              wr_idx = in_rx;
            end
            OP_MOVE: begin
              bus_c  = rd(in_ry);
              wr_en  = 1'b1;
              wr_idx = in_rx;
            end
            OP_BR: begin
              branch_c = 1'b1;
              baddr_c  = instruction[3:0];
            end
            default: ;
          endcase
        end
      end
      T1: begin
        bus_c    = rd(ir_rx);
        a_d      = bus_c;
        branch_c = 1'b1;
        baddr_c  = pc_q;
        state_d  = T2;
      end
      T2: begin
        bus_c    = rd(ir_ry);
        g_d      = alu(ir_op, a_q, bus_c);
        branch_c = 1'b1;
        baddr_c  = pc_q;
        state_d  = T3;
      end
      T3: begin
        bus_c   = g_q;
        wr_en   = 1'b1;
        done_c  = 1'b1;
        state_d = T0;
      end
    endcase

    // Write data always equals the bus value; NA and PC drop the write.
    for (int i = 1; i <= 6; i++)
      if (wr_en && wr_idx == ARG_SIZE'(i)) r_d[i] = bus_c;

    pc_d = branch_c ? baddr_c : pc_q + 4'd1;
  end

  // Outputs are forced quiet while reset is held.
  assign branch        = branch_c & ~rst;
  assign branchaddress = rst ? 4'd0 : baddr_c;
  assign bus           = rst ? '0 : bus_c;
  assign done          = done_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      pc_q    <= '0;
      for (int i = 1; i <= 6; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      pc_q    <= pc_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed + random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instruction;
  logic [7:0] data_in;
  logic       branch;
  logic [3:0] branchaddress;
  logic [7:0] bus;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  bit sub_en;

  int m_r [8];
  int m_pc;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .data_in       (data_in),
    .branch        (branch),
    .branchaddress (branchaddress),
    .bus           (bus),
    .done          (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_rd(input int idx);
    if (idx == 0) return 0;
    if (idx == 7) return m_pc;
    return m_r[idx];
  endfunction

  task automatic m_wr(input int idx, input int v);
    if (idx >= 1 && idx <= 6) m_r[idx] = v % 256;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_pc = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from T0 to completion, checking each cycle.
  task automatic exec(input int op, input int rx,
                      input int ry, input int din);
    string t;
    int    a, b, res;
    logic [3:0] op4;
    logic [2:0] rx3, ry3;
    op4 = op[3:0];
    rx3 = rx[2:0];
    ry3 = ry[2:0];
    instruction = {op4, rx3, ry3};
    data_in     = din[7:0];
    t = $sformatf("op%0d r%0d,r%0d", op, rx, ry);
    @(negedge clk);
    if (op == 2 || op == 3 || (op == 4 && sub_en)) begin
      a = m_rd(rx);
      b = m_rd(ry);
      if (op == 2) res = (a + b) % 256;
      else if (op == 3) res = a ^ b;
      else res = (a - b + 256) % 256;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) begin
          // Live word must be ignored once past T0.
          instruction = 10'($urandom);
          data_in     = 8'($urandom);
          @(negedge clk);
        end
        check({t, $sformatf(" c%0d bus", c)}, 32'(bus),
              c == 0 ? 0 : c == 1 ? a : c == 2 ? b : res);
        check({t, $sformatf(" c%0d branch", c)}, 32'(branch),
              c < 3 ? 1 : 0);
        check({t, $sformatf(" c%0d done", c)}, 32'(done),
              c == 3 ? 1 : 0);
        if (c < 3)
          check({t, $sformatf(" c%0d baddr", c)},
                32'(branchaddress), m_pc);
        next_cycle();
      end
      m_wr(rx, res);
      m_pc = (m_pc + 1) % 16;
    end else begin
      check({t, " done"}, 32'(done), 1);
      check({t, " branch"}, 32'(branch), op == 8 ? 1 : 0);
      if (op == 8)
        check({t, " baddr"}, 32'(branchaddress),
              (rx % 2) * 8 + ry);
      if (op == 0) check({t, " bus"}, 32'(bus), din % 256);
      else if (op == 1) check({t, " bus"}, 32'(bus), m_rd(ry));
      else check({t, " bus"}, 32'(bus), 0);
      next_cycle();
      if (op == 0) m_wr(rx, din);
      if (op == 1) m_wr(rx, m_rd(ry));
      if (op == 8) m_pc = (rx % 2) * 8 + ry;
      else m_pc = (m_pc + 1) % 16;
    end
  endtask

  task automatic read_reg(input int k);
    exec(1, 0, k, 0);
  endtask

  initial begin
`ifdef CU_SUB_EN
    sub_en = 1'b1;
`else
    sub_en = 1'b0;
`endif
    rst         = 1'b1;
    instruction = 10'b0000_001_000;
    data_in     = 8'hAA;
    m_reset();
    #2;
    check("rst branch", 32'(branch), 0);
    check("rst baddr", 32'(branchaddress), 0);
    check("rst bus", 32'(bus), 0);
    check("rst done", 32'(done), 0);
    next_cycle();
    rst = 1'b0;

    // LOAD then MOVE
    exec(0, 1, 0, 8'h5A);
    read_reg(1);
    check("load r1", 32'(m_r[1]), 8'h5A);
    exec(1, 2, 1, 0);
    read_reg(2);

    // ADD with wrap
    exec(0, 1, 0, 8'hF0);
    exec(0, 2, 0, 8'h20);
    exec(2, 1, 2, 0);
    read_reg(1);
    check("add wrap", 32'(m_r[1]), 8'h10);
    read_reg(7);

    // XOR with itself
    exec(0, 1, 0, 8'h3C);
    exec(3, 1, 1, 0);
    read_reg(1);

    // BR to 15 then wrap
    exec(8, 1, 7, 0);
    read_reg(7);
    read_reg(7);

    // Opcode 0100
    exec(0, 1, 0, 8'h05);
    exec(0, 2, 0, 8'h07);
    exec(4, 1, 2, 0);
    read_reg(1);
    check("op4 r1", 32'(m_r[1]), sub_en ? 8'hFE : 8'h05);

    // Reset asserted in T2 of an ADD
    instruction = 10'b0010_001_010;
    @(negedge clk);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    check("midrst branch", 32'(branch), 0);
    check("midrst done", 32'(done), 0);
    check("midrst bus", 32'(bus), 0);
    next_cycle();
    rst = 1'b0;
    m_reset();
    for (int k = 1; k <= 7; k++) read_reg(k);

    // Random instruction stream
    for (int n = 0; n < 300; n++)
      exec($urandom_range(0, 15), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 255));
    for (int k = 1; k <= 7; k++) read_reg(k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
